// File: rtl/uart_fifo_if.sv
// Byte-level handshake bundle between a uart_fifo core and its user.
// master: the user (CPU or bench) that writes TX bytes and acknowledges RX bytes.
// slave : the uart_fifo core.
//   tx_data/tx_wr          -> push a byte into the TX FIFO
//   tx_busy/tx_full        <- TX FIFO or shifter active / TX FIFO full
//   rx_data/rx_error       <- head of RX FIFO and its error tag
//   rx_avail/rx_ack        <- RX FIFO non-empty / -> pop RX head
//   rx_overrun/rx_level    <- sticky drop flag / RX FIFO occupancy
interface uart_fifo_if #(
    parameter int unsigned fifo_depth_log2 = 4
);
    logic [7:0]               tx_data;
    logic                     tx_wr;
    logic                     tx_busy;
    logic                     tx_full;
    logic [7:0]               rx_data;
    logic                     rx_avail;
    logic                     rx_ack;
    logic                     rx_error;
    logic                     rx_overrun;
    logic [fifo_depth_log2:0] rx_level;

    modport master (
        output tx_data, tx_wr, rx_ack,
        input  tx_busy, tx_full, rx_data, rx_avail, rx_error, rx_overrun, rx_level
    );

    modport slave (
        input  tx_data, tx_wr, rx_ack,
        output tx_busy, tx_full, rx_data, rx_avail, rx_error, rx_overrun, rx_level
    );
endinterface

// File: rtl/uart_fifo.sv
// UART with configurable frame format and a FIFO in each direction.
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   uart_rxd  serial input, idle high
//   uart_txd  serial output, idle high
//   bus       byte handshake (slave side of uart_fifo_if)
// RX FIFO entries carry {error, data}; error = frame or parity error on that byte.
module uart_fifo #(
    parameter int unsigned freq_hz         = 50000000,
    parameter int unsigned baud            = 115200,
    parameter int unsigned data_bits       = 8,
    parameter int unsigned parity          = 0,
    parameter int unsigned stop_bits       = 1,
    parameter int unsigned fifo_depth_log2 = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rxd,
    output logic       uart_txd,
    uart_fifo_if.slave bus
);
    localparam int unsigned DivRaw      = freq_hz / (baud * 16);
    localparam int unsigned Div         = (DivRaw < 1) ? 1 : DivRaw;
    localparam int unsigned DivW        = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned Aw          = fifo_depth_log2;
    localparam int unsigned Depth       = 2 ** fifo_depth_log2;
    localparam logic [7:0]  DataMask    = 8'((1 << data_bits) - 1);
    localparam logic [2:0]  LastDataBit = 3'(data_bits - 1);
    localparam logic [2:0]  LastStopBit = 3'(stop_bits - 1);
    localparam logic        OddPar      = (parity == 1);

    // ---------------------------------------------------------------- tick generator
    logic [DivW-1:0] tick_cnt;
    logic            tick;

    assign tick = (tick_cnt == DivW'(Div - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // ---------------------------------------------------------------- TX FIFO
    logic [7:0]  tx_mem [Depth];
    logic [Aw:0] tx_wptr, tx_rptr;
    logic        tx_empty, tx_full, tx_push, tx_pop;
    logic [7:0]  tx_head;

    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr[Aw] != tx_rptr[Aw]) && (tx_wptr[Aw-1:0] == tx_rptr[Aw-1:0]);
    assign tx_push  = bus.tx_wr && !tx_full;
    assign tx_head  = tx_mem[tx_rptr[Aw-1:0]];

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wptr[Aw-1:0]] <= bus.tx_data & DataMask;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     tx_wptr <= '0;
        else if (tx_push) tx_wptr <= tx_wptr + 1'b1;
    end

    // ---------------------------------------------------------------- TX FSM
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;

    tx_state_e  tx_state;
    logic [3:0] tx_sub;
    logic [2:0] tx_bit;
    logic [7:0] tx_shift;
    logic       tx_par;
    logic       txd;

    // A byte is taken from the FIFO on the tick that starts its start bit: from IDLE, or at
    // the end of the last stop bit so consecutive frames abut.
    assign tx_pop = tick && !tx_empty &&
                    ((tx_state == TxIdle) ||
                     (tx_state == TxStop && tx_sub == 4'd15 && tx_bit == LastStopBit));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TxIdle;
            tx_rptr  <= '0;
            tx_sub   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            txd      <= 1'b1;
        end else begin
            if (tx_pop) begin
                tx_rptr  <= tx_rptr + 1'b1;
                tx_shift <= tx_head;
                tx_par   <= (^tx_head) ^ OddPar;
                tx_state <= TxStart;
                tx_sub   <= '0;
                txd      <= 1'b0;
            end else if (tick) begin
                unique case (tx_state)
                    TxIdle: ;
                    TxStart: begin
                        tx_sub <= tx_sub + 1'b1;
                        if (tx_sub == 4'd15) begin
                            tx_state <= TxData;
                            tx_bit   <= '0;
                            txd      <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end
                    TxData: begin
                        tx_sub <= tx_sub + 1'b1;
                        if (tx_sub == 4'd15) begin
                            if (tx_bit == LastDataBit) begin
                                tx_bit <= '0;
                                if (parity != 0) begin
                                    tx_state <= TxParity;
                                    txd      <= tx_par;
                                end else begin
                                    tx_state <= TxStop;
                                    txd      <= 1'b1;
                                end
                            end else begin
                                tx_bit   <= tx_bit + 1'b1;
                                txd      <= tx_shift[0];
                                tx_shift <= tx_shift >> 1;
                            end
                        end
                    end
                    TxParity: begin
                        tx_sub <= tx_sub + 1'b1;
                        if (tx_sub == 4'd15) begin
                            tx_state <= TxStop;
                            tx_bit   <= '0;
                            txd      <= 1'b1;
                        end
                    end
                    TxStop: begin
                        tx_sub <= tx_sub + 1'b1;
                        if (tx_sub == 4'd15) begin
                            // Non-empty FIFO at this point was handled by tx_pop above.
                            if (tx_bit == LastStopBit) tx_state <= TxIdle;
                            else                       tx_bit   <= tx_bit + 1'b1;
                        end
                    end
                    default: tx_state <= TxIdle;
                endcase
            end
        end
    end

    assign uart_txd    = txd;
    assign bus.tx_busy = !tx_empty || (tx_state != TxIdle);
    assign bus.tx_full = tx_full;

    // ---------------------------------------------------------------- RX synchroniser
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rxd;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ---------------------------------------------------------------- RX FSM
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    rx_state_e  rx_state;
    logic [3:0] rx_sub;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;
    logic       rx_perr;
    logic       rx_push;
    logic [8:0] rx_word;

    // rx_sub runs freely once a start edge is seen; every bit is sampled when it reaches 8,
    // and the state advances at that same point, so the next sample lands one bit later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RxIdle;
            rx_sub   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
            rx_push  <= 1'b0;
            rx_word  <= '0;
        end else begin
            rx_push <= 1'b0;
            if (rx_state == RxIdle) begin
                if (rx_prev && !rx_sync) begin
                    rx_state <= RxStart;
                    rx_sub   <= '0;
                end
            end else if (tick) begin
                rx_sub <= rx_sub + 1'b1;
                if (rx_sub == 4'd7) begin
                    case (rx_state)
                        RxStart: begin
                            if (rx_sync) begin
                                rx_state <= RxIdle;     // glitch, not a start bit
                            end else begin
                                rx_state <= RxData;
                                rx_bit   <= '0;
                                rx_shift <= '0;
                                rx_perr  <= 1'b0;
                            end
                        end
                        RxData: begin
                            rx_shift[rx_bit] <= rx_sync;
                            if (rx_bit == LastDataBit) begin
                                rx_state <= (parity != 0) ? RxParity : RxStop;
                            end else begin
                                rx_bit <= rx_bit + 1'b1;
                            end
                        end
                        RxParity: begin
                            rx_perr  <= (rx_sync != ((^rx_shift) ^ OddPar));
                            rx_state <= RxStop;
                        end
                        RxStop: begin
                            rx_push  <= 1'b1;
                            rx_word  <= {rx_perr | !rx_sync, rx_shift};
                            rx_state <= RxIdle;
                        end
                        default: rx_state <= RxIdle;
                    endcase
                end
            end
        end
    end

    // ---------------------------------------------------------------- RX FIFO
    logic [8:0]  rx_mem [Depth];
    logic [Aw:0] rx_wptr, rx_rptr;
    logic        rx_empty, rx_full, rx_pop, rx_wr;
    logic [8:0]  rx_head;
    logic        rx_overrun;

    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr[Aw] != rx_rptr[Aw]) && (rx_wptr[Aw-1:0] == rx_rptr[Aw-1:0]);
    assign rx_pop   = bus.rx_ack && !rx_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign rx_wr    = rx_push && (!rx_full || rx_pop);
    assign rx_head  = rx_mem[rx_rptr[Aw-1:0]];

    always_ff @(posedge clk) begin
        if (rx_wr) rx_mem[rx_wptr[Aw-1:0]] <= rx_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_wptr    <= '0;
            rx_rptr    <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_wr)  rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop) rx_rptr <= rx_rptr + 1'b1;
            if (rx_push && !rx_wr) rx_overrun <= 1'b1;
            else if (bus.rx_ack)   rx_overrun <= 1'b0;
        end
    end

    assign bus.rx_avail   = !rx_empty;
    assign bus.rx_data    = rx_empty ? 8'h00 : rx_head[7:0];
    assign bus.rx_error   = rx_empty ? 1'b0 : rx_head[8];
    assign bus.rx_overrun = rx_overrun;
    assign bus.rx_level   = rx_wptr - rx_rptr;
endmodule

// File: tb/tb_uart_fifo.sv
`timescale 1ns/1ps
module tb_uart_fifo;
    localparam int unsigned FreqHz = 1600000;
    localparam int unsigned Baud   = 100000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 8N1 instance, txd looped back to rxd
    uart_fifo_if #(.fifo_depth_log2(4)) bus8 ();
    logic txd8;
    logic [7:0] tx_data8 = 8'h00;
    logic tx_wr8 = 1'b0, ack_mon8 = 1'b0, ack_man8 = 1'b0;
    assign bus8.tx_data = tx_data8;
    assign bus8.tx_wr   = tx_wr8;
    assign bus8.rx_ack  = ack_mon8 | ack_man8;

    uart_fifo #(.freq_hz(FreqHz), .baud(Baud), .data_bits(8), .parity(0), .stop_bits(1),
                .fifo_depth_log2(4)) u_dut8 (
        .clk(clk), .reset_n(reset_n), .uart_rxd(txd8), .uart_txd(txd8), .bus(bus8));

    // 7E1 instance, rxd driven by the bench
    uart_fifo_if #(.fifo_depth_log2(4)) bus7 ();
    logic txd7;
    logic drv7 = 1'b1;
    logic ack_mon7 = 1'b0;
    assign bus7.tx_data = 8'h00;
    assign bus7.tx_wr   = 1'b0;
    assign bus7.rx_ack  = ack_mon7;

    uart_fifo #(.freq_hz(FreqHz), .baud(Baud), .data_bits(7), .parity(2), .stop_bits(1),
                .fifo_depth_log2(4)) u_dut7 (
        .clk(clk), .reset_n(reset_n), .uart_rxd(drv7), .uart_txd(txd7), .bus(bus7));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboards: expected {error, data} pushed at stimulus time
    logic [8:0] exp8 [$];
    logic [8:0] exp7 [$];
    logic mon8 = 1'b0, mon7 = 1'b0;

    initial begin : monitor8
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (mon8 && bus8.rx_avail) begin
                if (exp8.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rx8_unexpected: got 0x%0h expected nothing", bus8.rx_data);
                end else begin
                    e = exp8.pop_front();
                    chk("rx8_byte", {bus8.rx_error, bus8.rx_data}, e);
                end
                ack_mon8 = 1'b1; @(negedge clk); ack_mon8 = 1'b0;
            end
        end
    end

    initial begin : monitor7
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (mon7 && bus7.rx_avail) begin
                if (exp7.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rx7_unexpected: got 0x%0h expected nothing", bus7.rx_data);
                end else begin
                    e = exp7.pop_front();
                    chk("rx7_byte", {bus7.rx_error, bus7.rx_data}, e);
                end
                ack_mon7 = 1'b1; @(negedge clk); ack_mon7 = 1'b0;
            end
        end
    end

    // Called at a negedge; tx_wr is high for exactly one rising edge.
    task automatic write8(input logic [7:0] d);
        tx_data8 = d; tx_wr8 = 1'b1;
        @(negedge clk);
        tx_wr8 = 1'b0;
    endtask

    task automatic drain8(input int budget);
        int n;
        n = 0;
        while ((exp8.size() != 0 || bus8.tx_busy) && n < budget) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("drain8_pending", exp8.size(), 0);
    endtask

    task automatic drain7(input int budget);
        int n;
        n = 0;
        while (exp7.size() != 0 && n < budget) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        chk("drain7_pending", exp7.size(), 0);
    endtask

    // 7E1 frame on drv7: start, 7 data LSB first, even parity, stop, then one idle bit.
    task automatic drive7(input logic [6:0] d, input logic bad_par, input logic bad_stop);
        logic [9:0] frame;
        frame = {~bad_stop, (^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drv7 = frame[i];
            repeat (16) @(negedge clk);
        end
        drv7 = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] b;
        logic [9:0] got;
        logic [7:0] bytes [17];
        int         n, acc;
        int unsigned w_cyc;

        // ---- reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", txd8, 1);
        chk("rst_txd7", txd7, 1);
        chk("rst_tx_busy", bus8.tx_busy, 0);
        chk("rst_tx_full", bus8.tx_full, 0);
        chk("rst_rx_avail", bus8.rx_avail, 0);
        chk("rst_rx_data", bus8.rx_data, 0);
        chk("rst_rx_error", bus8.rx_error, 0);
        chk("rst_rx_overrun", bus8.rx_overrun, 0);
        chk("rst_rx_level", bus8.rx_level, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // ---- loopback 0x55 with line waveform
        write8(8'h55);
        @(negedge clk);                    // first cycle of the start bit
        repeat (7) @(negedge clk);         // move to mid-bit
        for (int i = 0; i < 10; i++) begin
            got[i] = txd8;
            repeat (16) @(negedge clk);
        end
        chk("tx55_frame", got, {1'b1, 8'h55, 1'b0});
        n = 0;
        while (!bus8.rx_avail && n < 100) begin @(negedge clk); n++; end
        chk("lb55_avail", bus8.rx_avail, 1);
        chk("lb55_data", bus8.rx_data, 8'h55);
        chk("lb55_error", bus8.rx_error, 0);
        chk("lb55_level", bus8.rx_level, 1);
        chk("lb55_busy_done", bus8.tx_busy, 0);
        exp8.push_back({1'b0, 8'h55});
        mon8 = 1'b1;
        drain8(200);

        // ---- random loopback bytes
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            exp8.push_back({1'b0, b});
            write8(b);
        end
        drain8(8 * 170 + 200);

        // ---- burst 0x01.. until full; frames must abut on the line
        w_cyc = cyc + 1;
        acc = 0;
        for (int i = 1; i <= 20 && !bus8.tx_full; i++) begin
            b = 8'(i);
            exp8.push_back({1'b0, b});
            write8(b);
            acc++;
        end
        // one byte leaves for the shifter right away, so 16 or 17 writes fill it
        chk("burst_accept_count", (acc == 16 || acc == 17), 1);
        chk("burst_full", bus8.tx_full, 1);
        write8(8'hFF);                     // must be dropped
        chk("burst_full_after_drop", bus8.tx_full, 1);
        n = 0;
        while (bus8.tx_busy && n < 4000) begin @(negedge clk); n++; end
        chk("burst_gapless_end_cycle", cyc, w_cyc + 1 + 160 * acc);
        drain8(400);

        // ---- overrun: 17 frames, no acks
        mon8 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bytes[i] = 8'($urandom);
            write8(bytes[i]);
        end
        n = 0;
        while (bus8.tx_busy && n < 4000) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        chk("ovr_level", bus8.rx_level, 16);
        chk("ovr_flag", bus8.rx_overrun, 1);
        chk("ovr_head", {bus8.rx_error, bus8.rx_data}, {1'b0, bytes[0]});
        ack_man8 = 1'b1; @(negedge clk); ack_man8 = 1'b0;
        chk("ovr_flag_cleared", bus8.rx_overrun, 0);
        chk("ovr_level_after_ack", bus8.rx_level, 15);
        chk("ovr_new_head", bus8.rx_data, bytes[1]);
        for (int i = 1; i < 16; i++) exp8.push_back({1'b0, bytes[i]});
        mon8 = 1'b1;
        drain8(200);
        chk("ovr_empty_after_drain", bus8.rx_level, 0);

        // ---- 7E1: parity and framing
        mon7 = 1'b1;
        exp7.push_back({1'b1, 8'h41}); drive7(7'h41, 1'b1, 1'b0);
        exp7.push_back({1'b0, 8'h41}); drive7(7'h41, 1'b0, 1'b0);
        exp7.push_back({1'b1, 8'h2A}); drive7(7'h2A, 1'b0, 1'b1);
        drain7(100);

        // ---- glitch: 4-clk low pulse produces nothing
        drv7 = 1'b0; repeat (4) @(negedge clk); drv7 = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_level", bus7.rx_level, 0);
        chk("glitch_avail", bus7.rx_avail, 0);

        // ---- random 7E1 frames with random error injection
        for (int i = 0; i < 10; i++) begin
            logic [6:0] d;
            logic bp, bs;
            d  = 7'($urandom_range(0, 127));
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 3) == 0);
            exp7.push_back({bp | bs, 1'b0, d});
            drive7(d, bp, bs);
        end
        drain7(100);

        // ---- reset in the middle of a TX frame
        mon8 = 1'b0;
        write8(8'hC3); write8(8'h3C); write8(8'h99);
        repeat (60) @(negedge clk);        // inside the data bits of 0xC3
        chk("midrst_txd_before", txd8, 0);
        reset_n = 1'b0;
        #1;
        chk("midrst_txd", txd8, 1);
        chk("midrst_busy", bus8.tx_busy, 0);
        chk("midrst_full", bus8.tx_full, 0);
        chk("midrst_avail", bus8.rx_avail, 0);
        chk("midrst_level", bus8.rx_level, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("postrst_busy", bus8.tx_busy, 0);
        chk("postrst_txd", txd8, 1);
        chk("postrst_avail", bus8.rx_avail, 0);
        mon8 = 1'b1;
        exp8.push_back({1'b0, 8'hA5});
        write8(8'hA5);
        drain8(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
